marx_int_responder: RTL and testbench

Integer execution unit on the responder (marx) side of the shared CPU↔APU request/result protocol. It accepts downstream operation requests from one core port (req/ack), runs them through a fixed-latency pipeline, and returns results upstream in order (valid/ready). A credit counter bounds outstanding work, so a stalled consumer back-pressures the requester and never drops a result. It is the first shared integer co-processor slot behind the cluster's APU interconnect.

---
 rtl/marx_int_pkg.sv | 27 ++
 rtl/marx_result_fifo.sv | 88 ++++++++
 rtl/marx_int_responder.sv | 182 ++++++++++++++++++
 tb/tb_marx_int_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/marx_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : marx_int_pkg
// Description : Shared definitions for the marx integer responder. Holds the
//               opcode encoding and the bit position of the zero flag in the
//               upstream flag field.
// Revision    : 1.0 - initial release
// ============================================================================
package marx_int_pkg;

    // Downstream opcode encoding (3-bit field).
    typedef enum logic [2:0] {
        MARX_ADD = 3'd0,
        MARX_SUB = 3'd1,
        MARX_MAC = 3'd2,
        MARX_MIN = 3'd3,
        MARX_MAX = 3'd4,
        MARX_AND = 3'd5,
        MARX_OR  = 3'd6,
        MARX_XOR = 3'd7
    } marx_op_e;

    // Position of the zero flag inside the upstream flag vector.
    localparam int MARX_FLAG_ZERO = 0;

endpackage : marx_int_pkg
`default_nettype wire

// File: rtl/marx_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : marx_result_fifo
// Description : Parameterised synchronous FIFO holding finished results until
//               the upstream consumer takes them. Head entry is presented
//               combinationally; storage, pointers and fill level clear on an
//               asynchronous active-high reset.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               push       - write push_data this cycle (ignored when full)
//               push_data  - entry to write
//               pop        - drop the head entry this cycle (ignored when empty)
//               full/empty - fill status
//               head       - oldest stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module marx_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    // A 1-entry FIFO still needs a 1-bit pointer to keep the declarations legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : marx_result_fifo
`default_nettype wire

// File: rtl/marx_int_responder.sv
`default_nettype none
// ============================================================================
// Module      : marx_int_responder
// Description : Integer execution unit on the responder side of the CPU/APU
//               request/result protocol. Requests are accepted on a req/ack
//               handshake, evaluated by the ALU in the accept cycle, carried
//               through LATENCY valid-tagged stages and parked in a result FIFO
//               that drains upstream on valid/ready, strictly in order.
//               A credit counter (pipeline + FIFO occupancy) caps outstanding
//               work at DEPTH, so the FIFO can never overflow.
// Ports       : clk_i, rst_i            - clock, async active-high reset
//               req_ds_s_i / ack_ds_s_o - downstream request handshake
//               type_ds_d_i             - bit 0: signed MIN/MAX
//               operands_ds_d_i         - {c, b, a} packed, a in the low word
//               op_ds_d_i               - opcode (marx_op_e)
//               flags_ds_d_i            - ignored
//               valid_us_s_o / ready_us_s_i - upstream result handshake
//               result_us_d_o, flags_us_d_o - FIFO head (bit 0 = zero flag)
// Constraints : WRESULT == WARG, NARGS >= 3, LATENCY >= 1, DEPTH >= 1, WOP >= 3
// Revision    : 1.0 - initial release
// ============================================================================
module marx_int_responder
    import marx_int_pkg::*;
#(
    parameter int WOP      = 3,
    parameter int WAPUTYPE = 1,
    parameter int WARG     = 32,
    parameter int WRESULT  = 32,
    parameter int NARGS    = 3,
    parameter int NDSFLAGS = 1,
    parameter int NUSFLAGS = 1,
    parameter int LATENCY  = 2,
    parameter int DEPTH    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_ds_s_i,
    output logic                  ack_ds_s_o,
    input  logic [WAPUTYPE-1:0]   type_ds_d_i,
    input  logic [NARGS*WARG-1:0] operands_ds_d_i,
    input  logic [WOP-1:0]        op_ds_d_i,
    input  logic [NDSFLAGS-1:0]   flags_ds_d_i,
    output logic                  valid_us_s_o,
    input  logic                  ready_us_s_i,
    output logic [WRESULT-1:0]    result_us_d_o,
    output logic [NUSFLAGS-1:0]   flags_us_d_o
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DATA_W = WRESULT + NUSFLAGS;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic [WARG-1:0] w_a;
    logic [WARG-1:0] w_b;
    logic [WARG-1:0] w_c;
    marx_op_e        w_op;
    logic            w_signed;

    assign w_a      = operands_ds_d_i[0*WARG +: WARG];
    assign w_b      = operands_ds_d_i[1*WARG +: WARG];
    assign w_c      = operands_ds_d_i[2*WARG +: WARG];
    assign w_op     = marx_op_e'(op_ds_d_i[2:0]);
    assign w_signed = type_ds_d_i[0];

    // Inputs (or parts of them) that carry no meaning for this unit.
    logic w_unused;
    logic w_fifo_full;
    assign w_unused = ^{flags_ds_d_i, type_ds_d_i, op_ds_d_i, operands_ds_d_i, w_fifo_full};

    // ------------------------------------------------------------------
    // ALU: evaluated on the live request; only captured on a transfer.
    // ------------------------------------------------------------------
    logic [WRESULT-1:0]  w_alu;
    logic [NUSFLAGS-1:0] w_flags;
    logic                w_a_lt_b;

    always_comb begin
        w_a_lt_b = 1'b0;
        if (w_signed) begin
            w_a_lt_b = ($signed(w_a) < $signed(w_b));
        end else begin
            w_a_lt_b = (w_a < w_b);
        end
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            MARX_ADD: w_alu = w_a + w_b;
            MARX_SUB: w_alu = w_a - w_b;
            MARX_MAC: w_alu = (w_a * w_b) + w_c;
            MARX_MIN: w_alu = w_a_lt_b ? w_a : w_b;
            MARX_MAX: w_alu = w_a_lt_b ? w_b : w_a;
            MARX_AND: w_alu = w_a & w_b;
            MARX_OR:  w_alu = w_a | w_b;
            MARX_XOR: w_alu = w_a ^ w_b;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_flags                 = '0;
        w_flags[MARX_FLAG_ZERO] = (w_alu == '0);
    end

    // ------------------------------------------------------------------
    // Handshakes and credit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic              w_xfer;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;

    // ack depends only on req and the registered credit count, never on ready.
    assign ack_ds_s_o   = !rst_i && req_ds_s_i && (r_cnt < CNT_W'(DEPTH));
    assign w_xfer       = req_ds_s_i && ack_ds_s_o;
    assign valid_us_s_o = !rst_i && !w_fifo_empty;
    assign w_pop        = valid_us_s_o && ready_us_s_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_xfer, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fixed-latency pipeline. No stall is needed: the credit bound
    // guarantees the FIFO has room for everything in flight.
    // ------------------------------------------------------------------
    logic              r_vld  [LATENCY];
    logic [DATA_W-1:0] r_data [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_xfer;
            if (w_xfer) begin
                r_data[0] <= {w_flags, w_alu};
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    marx_result_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (r_vld[LATENCY-1]),
        .push_data (r_data[LATENCY-1]),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    // Outputs are forced to zero whenever no result is presented (incl. reset).
    assign result_us_d_o = valid_us_s_o ? w_fifo_head[WRESULT-1:0]      : '0;
    assign flags_us_d_o  = valid_us_s_o ? w_fifo_head[DATA_W-1:WRESULT] : '0;

endmodule : marx_int_responder
`default_nettype wire

// File: tb/tb_marx_int_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_marx_int_responder
// Description : Scoreboard bench for marx_int_responder (default parameters).
//               The driver pushes the hand-computed result of every accepted
//               request; an independent monitor pops and compares on each
//               upstream valid && ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_marx_int_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ack;
    logic [0:0]  typ;
    logic [95:0] operands;
    logic [2:0]  opc;
    logic [0:0]  dsflags;
    logic        valid;
    logic        ready;
    logic [31:0] result;
    logic [0:0]  usflags;

    int tests = 0;
    int fails = 0;
    logic [32:0] sb[$];   // {zero_flag, result}

    always #5 clk = ~clk;

    marx_int_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_ds_s_i      (req),
        .ack_ds_s_o      (ack),
        .type_ds_d_i     (typ),
        .operands_ds_d_i (operands),
        .op_ds_d_i       (opc),
        .flags_ds_d_i    (dsflags),
        .valid_us_s_o    (valid),
        .ready_us_s_i    (ready),
        .result_us_d_o   (result),
        .flags_us_d_o    (usflags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic t,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        req      = 1'b1;
        opc      = o;
        typ      = t;
        operands = {c, b, a};
    endtask

    task automatic idle();
        req = 1'b0;
    endtask

    // Offer a request until accepted (bounded), then record the expected result.
    task automatic send(input logic [2:0] o, input logic t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp_res);
        bit got;
        got = 1'b0;
        drive(o, t, a, b, c);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        check("send_accepted", 64'(got), 64'd1);
        if (got) sb.push_back({(exp_res == 32'd0), exp_res});
        @(posedge clk); #1;
    endtask

    // One cycle offering ADD a+0 with a required ack value.
    task automatic step_ack(input logic exp_ack, input logic [31:0] a);
        drive(3'd0, 1'b0, a, 32'd0, 32'd0);
        @(negedge clk);
        check("ack_cycle", 64'(ack), 64'(exp_ack));
        if (ack) sb.push_back({(a == 32'd0), a});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compares every upstream transfer against the scoreboard.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got 0x%0h, expected no result at %0t", result, $time);
            end else begin
                exp = sb.pop_front();
                check("result", 64'(result), 64'(exp[31:0]));
                check("zero_flag", 64'(usflags), 64'(exp[32]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        req      = 1'b1;
        ready    = 1'b0;
        opc      = 3'd0;
        typ      = 1'b0;
        operands = '0;
        dsflags  = 1'b0;

        // Reset state, with req held high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(usflags), 64'd0);

        // First cycle after release: ack follows req. ADD 5+7, latency check.
        @(posedge clk); #1;
        rst   = 1'b0;
        ready = 1'b1;
        drive(3'd0, 1'b0, 32'd5, 32'd7, 32'd0);
        @(negedge clk);
        check("first_cycle_ack", 64'(ack), 64'd1);
        if (ack) sb.push_back({1'b0, 32'd12});
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        check("valid_t+1", 64'(valid), 64'd0);
        @(negedge clk);
        check("valid_t+2", 64'(valid), 64'd0);
        @(negedge clk);
        check("valid_t+3", 64'(valid), 64'd1);
        @(posedge clk); #1;

        // ALU vectors, back to back.
        send(3'd1, 1'b0, 32'd7,        32'd7,        32'd0, 32'd0);
        send(3'd2, 1'b0, 32'hFFFFFFFF, 32'd2,        32'd3, 32'h00000001);
        send(3'd3, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0, 32'hFFFFFFFF);
        send(3'd3, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0, 32'h00000001);
        send(3'd4, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0, 32'h00000001);
        send(3'd4, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0, 32'hFFFFFFFF);
        send(3'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0, 32'h00000000);
        send(3'd1, 1'b0, 32'd0,        32'd1,        32'd0, 32'hFFFFFFFF);
        send(3'd5, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h0000F000);
        send(3'd6, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h0000FFF0);
        send(3'd7, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h00000FF0);
        send(3'd7, 1'b0, 32'h12345678, 32'h12345678, 32'd0, 32'h00000000);
        idle();
        drain();

        // Backpressure: 8 cycles of req with ready low -> exactly 4 accepts.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_ack(i < 4, 32'(i));
        end
        // Raise ready: pop in this cycle, ack only from the next one.
        ready = 1'b1;
        step_ack(1'b0, 32'd100);
        step_ack(1'b1, 32'd100);
        idle();
        drain();

        // cnt=3 with accept and pop in the same cycle.
        ready = 1'b0;
        step_ack(1'b1, 32'd10);
        step_ack(1'b1, 32'd11);
        step_ack(1'b1, 32'd12);
        idle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) break;
        end
        check("head_valid_before_pop", 64'(valid), 64'd1);
        @(posedge clk); #1;
        ready = 1'b1;
        step_ack(1'b1, 32'd13);   // accept + pop: count stays at 3
        ready = 1'b0;
        step_ack(1'b1, 32'd14);   // count reaches 4
        step_ack(1'b0, 32'd15);
        step_ack(1'b0, 32'd16);
        idle();
        ready = 1'b1;
        drain();

        // Reset with three operations outstanding.
        ready = 1'b0;
        step_ack(1'b1, 32'd20);
        step_ack(1'b1, 32'd21);
        step_ack(1'b1, 32'd22);
        drive(3'd0, 1'b0, 32'd30, 32'd0, 32'd0);
        ready = 1'b1;
        rst   = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_flags", 64'(usflags), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", 64'(valid), 64'd0);
        end
        @(posedge clk); #1;
        send(3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd3);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_marx_int_responder
`default_nettype wire
